// File: rtl/fuzz_report_pkg.sv
// rtl/fuzz_report_pkg.sv - shared constants, state codes and report entry type for the fuzz report collector
package fuzz_report_pkg;
    localparam logic [31:0] REPORT_ADDR_DEFAULT = 32'h8000_0000;

    localparam logic [15:0] CLS_CRASH = 16'hDEAD;
    localparam logic [15:0] CLS_HANG  = 16'hBEEF;
    localparam logic [15:0] CLS_OVF   = 16'hC0DE;
    localparam logic [15:0] CLS_MISM  = 16'hFFFF;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;

    // Wide enough for any practical satellite count; the top truncates to its own id width.
    localparam int SAT_ID_MAX_W = 8;

    typedef struct packed {
        logic [SAT_ID_MAX_W-1:0] sat_id;
        logic [31:0]             status;
    } rpt_entry_t;
endpackage

// File: rtl/fuzz_report_fifo.sv
// rtl/fuzz_report_fifo.sv - synchronous first-word-fall-through FIFO with full, empty and level
module fuzz_report_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 40,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/fuzz_report_collector.sv
// rtl/fuzz_report_collector.sv - round-robin satellite report collector feeding a host FIFO
// Per-class statistics counters are built only when FUZZ_COLLECT_STATS_EN is defined.
module fuzz_report_collector
    import fuzz_report_pkg::*;
#(
    parameter int NUM_SAT      = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int EXT_RW_WIDTH = 256,
    parameter int FIFO_DEPTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] REPORT_ADDR = ADDR_WIDTH'(REPORT_ADDR_DEFAULT),
    parameter int CNT_WIDTH    = 16,
    localparam int SID_W = (NUM_SAT > 1) ? $clog2(NUM_SAT) : 1,
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SAT-1:0]              sat_req,
    input  logic [NUM_SAT-1:0]              sat_we,
    input  logic [NUM_SAT*ADDR_WIDTH-1:0]   sat_addr_write,
    input  logic [NUM_SAT*EXT_RW_WIDTH-1:0] sat_wdata,
    output logic [NUM_SAT-1:0]              sat_write_done,
    output logic                            rpt_valid,
    input  logic                            rpt_ready,
    output logic [SID_W-1:0]                rpt_sat_id,
    output logic [31:0]                     rpt_status,
    output logic [LVL_W-1:0]                fifo_level,
    input  logic                            stats_clr,
    output logic [CNT_WIDTH-1:0]            cnt_crash,
    output logic [CNT_WIDTH-1:0]            cnt_hang,
    output logic [CNT_WIDTH-1:0]            cnt_ovf,
    output logic [CNT_WIDTH-1:0]            cnt_mism
);
    localparam logic [SID_W-1:0] LAST_SID = SID_W'(NUM_SAT - 1);

    logic [1:0]         state;
    logic [SID_W-1:0]   rr_ptr;
    logic [SID_W-1:0]   grant;
    logic [SID_W-1:0]   next_grant;
    logic               found;
    logic [31:0]        status;
    logic [NUM_SAT-1:0] armed;
    logic [NUM_SAT-1:0] pend;
    logic [31:0]        word      [NUM_SAT];
    logic [31:0]        last_word [NUM_SAT];
    logic               fifo_full;
    logic               fifo_empty;
    rpt_entry_t         push_entry;
    rpt_entry_t         head;

    always_comb begin
        pend = '0;
        for (int i = 0; i < NUM_SAT; i++) begin
            word[i] = sat_wdata[i*EXT_RW_WIDTH +: 32];
            pend[i] = sat_req[i] & sat_we[i] & armed[i]
                    & (sat_addr_write[i*ADDR_WIDTH +: ADDR_WIDTH] == REPORT_ADDR);
        end
    end

    // First pending channel at or after rr_ptr, wrapping modulo NUM_SAT.
    always_comb begin
        int idx;
        found      = 1'b0;
        next_grant = rr_ptr;
        idx        = 0;
        for (int k = 0; k < NUM_SAT; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_SAT) idx = idx - NUM_SAT;
            if (!found && pend[idx]) begin
                found      = 1'b1;
                next_grant = SID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            grant  <= '0;
            status <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found && !fifo_full) begin
                        grant  <= next_grant;
                        status <= word[next_grant];
                        state  <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: state <= ST_ACK;
                ST_ACK: begin
                    rr_ptr <= (grant == LAST_SID) ? '0 : grant + 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A channel disarms on acceptance and re-arms on a req gap or a new status word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed <= '1;
            for (int i = 0; i < NUM_SAT; i++) last_word[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SAT; i++) begin
                if (state == ST_ACK && grant == SID_W'(i)) begin
                    armed[i]     <= 1'b0;
                    last_word[i] <= status;
                end else if (!sat_req[i] || word[i] != last_word[i]) begin
                    armed[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        sat_write_done = '0;
        if (state == ST_ACK) sat_write_done[grant] = 1'b1;
    end

    assign push_entry.sat_id = SAT_ID_MAX_W'(grant);
    assign push_entry.status = status;

    fuzz_report_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(rpt_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (state == ST_CAPTURE),
        .din   (push_entry),
        .pop   (rpt_ready),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign rpt_valid  = ~fifo_empty;
    assign rpt_sat_id = head.sat_id[SID_W-1:0];
    assign rpt_status = head.status;

`ifdef FUZZ_COLLECT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst || stats_clr) begin
            cnt_crash <= '0;
            cnt_hang  <= '0;
            cnt_ovf   <= '0;
            cnt_mism  <= '0;
        end else if (state == ST_CAPTURE) begin
            case (status[31:16])
                CLS_CRASH: if (cnt_crash != '1) cnt_crash <= cnt_crash + 1'b1;
                CLS_HANG:  if (cnt_hang  != '1) cnt_hang  <= cnt_hang  + 1'b1;
                CLS_OVF:   if (cnt_ovf   != '1) cnt_ovf   <= cnt_ovf   + 1'b1;
                CLS_MISM:  if (cnt_mism  != '1) cnt_mism  <= cnt_mism  + 1'b1;
                default: ;
            endcase
        end
    end
`else
    assign cnt_crash = '0;
    assign cnt_hang  = '0;
    assign cnt_ovf   = '0;
    assign cnt_mism  = '0;
`endif
endmodule

// File: tb/tb_fuzz_report_collector.sv
// tb/tb_fuzz_report_collector.sv - self-checking bench for fuzz_report_collector (honours FUZZ_COLLECT_STATS_EN)
module tb_fuzz_report_collector;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 256;
    localparam int FD = 8;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [31:0] RA = 32'h8000_0000;

    logic               clk = 1'b0;
    logic               rst;
    logic [NS-1:0]      sat_req;
    logic [NS-1:0]      sat_we;
    logic [NS*AW-1:0]   sat_addr_write;
    logic [NS*DW-1:0]   sat_wdata;
    logic [NS-1:0]      sat_write_done;
    logic               rpt_valid;
    logic               rpt_ready;
    logic [1:0]         rpt_sat_id;
    logic [31:0]        rpt_status;
    logic [3:0]         fifo_level;
    logic               stats_clr;
    logic [CW-1:0]      cnt_crash, cnt_hang, cnt_ovf, cnt_mism;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fuzz_report_collector #(
        .NUM_SAT(NS), .ADDR_WIDTH(AW), .EXT_RW_WIDTH(DW), .FIFO_DEPTH(FD), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .sat_req(sat_req), .sat_we(sat_we),
        .sat_addr_write(sat_addr_write), .sat_wdata(sat_wdata), .sat_write_done(sat_write_done),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_sat_id(rpt_sat_id),
        .rpt_status(rpt_status), .fifo_level(fifo_level), .stats_clr(stats_clr),
        .cnt_crash(cnt_crash), .cnt_hang(cnt_hang), .cnt_ovf(cnt_ovf), .cnt_mism(cnt_mism)
    );

    // Transaction-level reference: report queue, arm flags, round-robin pointer, report in flight.
    typedef struct { int id; logic [31:0] st; } ent_t;
    ent_t        mq[$];
    bit          m_armed[NS];
    logic [31:0] m_last[NS];
    int          m_rr, m_phase, m_gid;
    logic [31:0] m_gword;
    int          m_cnt[4];

    function automatic int class_of(logic [31:0] w);
        case (w[31:16])
            16'hDEAD: return 0;
            16'hBEEF: return 1;
            16'hC0DE: return 2;
            16'hFFFF: return 3;
            default:  return -1;
        endcase
    endfunction

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < NS; i++) begin m_armed[i] = 1'b1; m_last[i] = '0; end
        m_rr = 0; m_phase = 0; m_gid = 0; m_gword = '0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    endfunction

    function automatic void model_step();
        int  qsz = mq.size();
        int  g   = -1;
        int  cls = class_of(m_gword);
        bit  do_pop = rpt_ready && (qsz != 0);
        if (rst) begin model_reset(); return; end
`ifdef FUZZ_COLLECT_STATS_EN
        if (stats_clr) for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        else if (m_phase == 1 && cls >= 0 && m_cnt[cls] < CMAX) m_cnt[cls]++;
`endif
        if (m_phase == 0) begin
            for (int k = 0; k < NS; k++) begin
                int i = (m_rr + k) % NS;
                if (g < 0 && sat_req[i] && sat_we[i] && m_armed[i] && sat_addr_write[i*AW +: AW] == RA)
                    g = i;
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (m_phase == 2 && i == m_gid) begin
                m_armed[i] = 1'b0;
                m_last[i]  = m_gword;
            end else if (!sat_req[i] || sat_wdata[i*DW +: 32] != m_last[i]) begin
                m_armed[i] = 1'b1;
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (m_phase == 1) mq.push_back('{m_gid, m_gword});
        case (m_phase)
            0: if (g >= 0 && qsz < FD) begin m_gid = g; m_gword = sat_wdata[g*DW +: 32]; m_phase = 1; end
            1: m_phase = 2;
            default: begin m_rr = (m_gid + 1) % NS; m_phase = 0; end
        endcase
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [NS-1:0] exp_done = (m_phase == 2) ? NS'(1 << m_gid) : '0;
        chk("write_done", 64'(sat_write_done), 64'(exp_done));
        chk("rpt_valid", 64'(rpt_valid), 64'(mq.size() != 0));
        chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
        if (mq.size() != 0)
            chk("head", {rpt_sat_id, rpt_status}, {2'(mq[0].id), mq[0].st});
        chk("counters", {cnt_crash, cnt_hang, cnt_ovf, cnt_mism},
            {CW'(m_cnt[0]), CW'(m_cnt[1]), CW'(m_cnt[2]), CW'(m_cnt[3])});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_sat(int i, bit r, bit we, logic [31:0] addr, logic [31:0] w);
        sat_req[i] = r;
        sat_we[i]  = we;
        sat_addr_write[i*AW +: AW] = addr;
        sat_wdata[i*DW +: DW] = {{7{$urandom}}, w};
    endtask

    task automatic drain();
        rpt_ready = 1'b1;
        for (int k = 0; k < 20 && (mq.size() != 0 || m_phase != 0); k++) tick();
        rpt_ready = 1'b0;
        chk("drain_empty", 64'(fifo_level), 64'd0);
    endtask

    initial begin
        rst = 1'b1; rpt_ready = 1'b0; stats_clr = 1'b0;
        sat_req = '0; sat_we = '0; sat_addr_write = '0; sat_wdata = '0;
        model_reset();
        run(2);
        chk("reset_level", 64'(fifo_level), 64'd0);
        rst = 1'b0;
        run(1);

        // single report from satellite 2, done two cycles after request
        set_sat(2, 1, 1, RA, 32'hDEAD_0001);
        run(1);
        chk("t1_no_early_done", 64'(sat_write_done), 64'd0);
        run(1);
        chk("t1_done", 64'(sat_write_done), 64'b0100);
        chk("t1_head", {rpt_valid, rpt_sat_id, rpt_status}, {1'b1, 2'd2, 32'hDEAD_0001});
        set_sat(2, 0, 0, 0, 0);
        run(2);
        drain();

        // move rr_ptr to 1, then three simultaneous requests
        set_sat(0, 1, 1, RA, 32'h0000_1111);
        run(3);
        set_sat(0, 0, 0, 0, 0);
        run(2);
        drain();
        set_sat(0, 1, 1, RA, 32'h0000_00A0);
        set_sat(1, 1, 1, RA, 32'h0000_00A1);
        set_sat(3, 1, 1, RA, 32'h0000_00A3);
        run(12);
        chk("t2_level", 64'(fifo_level), 64'd3);
        chk("t2_first", 64'(rpt_sat_id), 64'd1);
        rpt_ready = 1'b1; run(1); rpt_ready = 1'b0;
        chk("t2_second", 64'(rpt_sat_id), 64'd3);
        rpt_ready = 1'b1; run(1); rpt_ready = 1'b0;
        chk("t2_third", 64'(rpt_sat_id), 64'd0);
        set_sat(1, 0, 0, 0, 0);
        set_sat(3, 0, 0, 0, 0);
        drain();

        // satellite 0 holds req: no repeat until its word changes
        run(6);
        chk("t3_no_repeat", 64'(fifo_level), 64'd0);
        sat_wdata[31:0] = 32'hBEEF_0001;
        run(5);
        chk("t3_rereport", {fifo_level, rpt_status}, {4'd1, 32'hBEEF_0001});
        set_sat(0, 0, 0, 0, 0);
        drain();

        // fill the FIFO, then a request must wait for a pop
        for (int k = 0; k < FD; k++) begin
            set_sat(k % NS, 1, 1, RA, 32'h1000_0000 + k);
            run(4);
            set_sat(k % NS, 0, 0, 0, 0);
            run(1);
        end
        chk("t4_full", 64'(fifo_level), 64'd8);
        set_sat(1, 1, 1, RA, 32'hC0DE_0009);
        run(5);
        chk("t4_blocked", {fifo_level, sat_write_done}, {4'd8, 4'd0});
        rpt_ready = 1'b1; run(1); rpt_ready = 1'b0;
        run(1);
        chk("t4_wait", 64'(sat_write_done), 64'd0);
        run(1);
        chk("t4_done", 64'(sat_write_done), 64'b0010);
        set_sat(1, 0, 0, 0, 0);
        drain();

        // wrong address and we=0 are ignored
        set_sat(3, 1, 1, RA + 32'd4, 32'hDEAD_0003);
        run(4);
        set_sat(3, 1, 0, RA, 32'hDEAD_0004);
        run(4);
        chk("t5_ignored", 64'(fifo_level), 64'd0);
        set_sat(3, 0, 0, 0, 0);
        run(1);

        // reset while a report is in CAPTURE
        set_sat(2, 1, 1, RA, 32'hFFFF_0002);
        run(1);
        chk("t6_in_capture", 64'(m_phase), 64'd1);
        rst = 1'b1;
        set_sat(2, 0, 0, 0, 0);
        #1;
        model_reset();
        check_outputs();
        chk("t6_async_reset", {fifo_level, rpt_valid, sat_write_done}, 64'd0);
        run(1);
        rst = 1'b0;
        run(4);

        // repeated mismatch reports drive cnt_mism into saturation
        rpt_ready = 1'b1;
        for (int k = 0; k < CMAX + 4; k++) begin
            set_sat(0, 1, 1, RA, 32'hFFFF_0000 + k);
            run(4);
        end
        set_sat(0, 0, 0, 0, 0);
        drain();
`ifdef FUZZ_COLLECT_STATS_EN
        chk("sat_mism", 64'(cnt_mism), 64'(CMAX));
`else
        chk("stats_off", 64'(cnt_mism), 64'd0);
`endif
        stats_clr = 1'b1; run(1); stats_clr = 1'b0;
        chk("stats_clr", 64'(cnt_mism), 64'd0);

        // randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NS; i++) begin
                logic [31:0] w;
                case ($urandom_range(3))
                    0: w = 32'hDEAD_0000;
                    1: w = 32'hBEEF_0000;
                    2: w = 32'hC0DE_0000;
                    default: w = 32'hFFFF_0000;
                endcase
                w[1:0] = 2'($urandom_range(1));
                set_sat(i, $urandom_range(1), $urandom_range(3) != 0,
                        ($urandom_range(3) != 0) ? RA : RA + 32'd4, w);
            end
            rpt_ready = ($urandom_range(2) == 0);
            stats_clr = ($urandom_range(31) == 0);
            tick();
        end
        sat_req = '0; stats_clr = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
